// File: rtl/secuenciador_suma.sv
// Control FSM for the two-operand BCD adder datapath.
// Turns operator pulses into one-cycle datapath strobes and the add handshake.
module secuenciador_suma #(
  parameter int MAX_DIGITS  = 3,
  parameter int ACK_TIMEOUT = 1023
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       push,
  input  logic [3:0] entrada,
  input  logic       guardar,
  input  logic       finalizar,
  input  logic       add_ack,
  output logic       ld_dig,
  output logic       clr_num,
  output logic       ld_sv,
  output logic       clr_sv,
  output logic       add_req,
  output logic       ent,
  output logic [2:0] n_dig,
  output logic [1:0] estado,
  output logic       err
);

  typedef enum logic [1:0] {
    ENTRY_A = 2'd0,
    ENTRY_B = 2'd1,
    SUMA    = 2'd2,
    MOSTRAR = 2'd3
  } state_t;

  localparam int TW = (ACK_TIMEOUT < 2) ? 1 : $clog2(ACK_TIMEOUT + 1);
  localparam logic [TW-1:0] T_LAST = TW'(ACK_TIMEOUT - 1);
  localparam logic [TW-1:0] T_MAX  = '1;
  localparam logic [2:0]    N_MAX  = 3'(MAX_DIGITS);

  state_t        state_q;
  logic [TW-1:0] timer_q;
  logic          ld_dig_q, clr_num_q, ld_sv_q, clr_sv_q;
  logic          add_req_q, ent_q, err_q;
  logic [2:0]    n_dig_q;

  logic fin_d, grd_d, psh_d;

  // Resolve simultaneous pulses: finalizar beats guardar beats push.
  always_comb begin
    fin_d = finalizar;
    grd_d = guardar & ~finalizar;
    psh_d = push & ~guardar & ~finalizar;
  end

  // Single-process FSM with every output registered.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ENTRY_A;
      timer_q   <= '0;
      ld_dig_q  <= 1'b0;
      clr_num_q <= 1'b0;
      ld_sv_q   <= 1'b0;
      clr_sv_q  <= 1'b0;
      add_req_q <= 1'b0;
      ent_q     <= 1'b0;
      err_q     <= 1'b0;
      n_dig_q   <= 3'd0;
    end else begin
      ld_dig_q  <= 1'b0;
      clr_num_q <= 1'b0;
      ld_sv_q   <= 1'b0;
      clr_sv_q  <= 1'b0;
      unique case (state_q)
        ENTRY_A, ENTRY_B: begin
          if (fin_d) begin
            if (state_q == ENTRY_B && n_dig_q != 3'd0) begin
              add_req_q <= 1'b1;
              timer_q   <= '0;
              state_q   <= SUMA;
            end
          end else if (grd_d) begin
            if (state_q == ENTRY_A && n_dig_q != 3'd0) begin
              ld_sv_q   <= 1'b1;
              clr_num_q <= 1'b1;
              n_dig_q   <= 3'd0;
              state_q   <= ENTRY_B;
            end
          end else if (psh_d) begin
            if (entrada > 4'd9) begin
              err_q <= 1'b1;
            end else if (n_dig_q < N_MAX) begin
              ld_dig_q <= 1'b1;
              n_dig_q  <= n_dig_q + 3'd1;
              err_q    <= 1'b0;
            end
          end
        end
        SUMA: begin
          if (add_ack) begin
            add_req_q <= 1'b0;
            ent_q     <= 1'b1;
            state_q   <= MOSTRAR;
          end else if (timer_q == T_LAST) begin
            add_req_q <= 1'b0;
            clr_num_q <= 1'b1;
            clr_sv_q  <= 1'b1;
            err_q     <= 1'b1;
            n_dig_q   <= 3'd0;
            state_q   <= ENTRY_A;
          end else if (timer_q != T_MAX) begin
            timer_q <= timer_q + 1'b1;
          end
        end
        MOSTRAR: begin
          if (psh_d) begin
            clr_num_q <= 1'b1;
            clr_sv_q  <= 1'b1;
            ent_q     <= 1'b0;
            err_q     <= 1'b0;
            n_dig_q   <= 3'd0;
            state_q   <= ENTRY_A;
          end
        end
        default: state_q <= ENTRY_A;
      endcase
    end
  end

  assign ld_dig  = ld_dig_q;
  assign clr_num = clr_num_q;
  assign ld_sv   = ld_sv_q;
  assign clr_sv  = clr_sv_q;
  assign add_req = add_req_q;
  assign ent     = ent_q;
  assign n_dig   = n_dig_q;
  assign estado  = state_q;
  assign err     = err_q;

endmodule

// File: tb/tb_secuenciador_suma.sv
// Bench for secuenciador_suma: directed steps then random pulses,
// compared each cycle against an operand-queue model.
module tb_secuenciador_suma;

  localparam int MAXD = 3;
  localparam int TO   = 8;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       push = 1'b0;
  logic [3:0] entrada = 4'd0;
  logic       guardar = 1'b0;
  logic       finalizar = 1'b0;
  logic       add_ack = 1'b0;
  logic       ld_dig, clr_num, ld_sv, clr_sv, add_req, ent, err;
  logic [2:0] n_dig;
  logic [1:0] estado;

  int tests = 0;
  int fails = 0;

  // model state: phase 0=A,1=B,2=waiting sum,3=showing sum
  int phase = 0;
  int digs[$];
  bit m_err = 0;
  int waited = 0;
  bit m_ld, m_cn, m_sv, m_cs;

  secuenciador_suma #(.MAX_DIGITS(MAXD), .ACK_TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .push(push), .entrada(entrada),
    .guardar(guardar), .finalizar(finalizar), .add_ack(add_ack),
    .ld_dig(ld_dig), .clr_num(clr_num), .ld_sv(ld_sv),
    .clr_sv(clr_sv), .add_req(add_req), .ent(ent),
    .n_dig(n_dig), .estado(estado), .err(err)
  );

  always #5 clk = ~clk;

  function automatic logic [12:0] obs();
    return {ld_dig, clr_num, ld_sv, clr_sv, add_req, ent,
            n_dig, estado, err};
  endfunction

  function automatic logic [12:0] expv();
    logic [2:0] n;
    logic [1:0] s;
    n = 3'(digs.size());
    s = 2'(phase);
    return {m_ld, m_cn, m_sv, m_cs, phase == 2, phase == 3,
            n, s, m_err};
  endfunction

  task automatic check(input string tag);
    logic [12:0] o, e;
    o = obs();
    e = expv();
    tests++;
    assert (o === e) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, o, e);
    end
  endtask

  task automatic model_reset();
    phase = 0;
    digs.delete();
    m_err = 0;
    waited = 0;
    {m_ld, m_cn, m_sv, m_cs} = '0;
  endtask

  task automatic model(input bit p, input int d, input bit g,
                       input bit f, input bit a);
    bit gg, pp;
    gg = g && !f;
    pp = p && !g && !f;
    {m_ld, m_cn, m_sv, m_cs} = '0;
    case (phase)
      0, 1: begin
        if (f) begin
          if (phase == 1 && digs.size() > 0) begin
            phase = 2;
            waited = 1;
          end
        end else if (gg) begin
          if (phase == 0 && digs.size() > 0) begin
            m_sv = 1; m_cn = 1;
            digs.delete();
            phase = 1;
          end
        end else if (pp) begin
          if (d > 9) m_err = 1;
          else if (digs.size() < MAXD) begin
            digs.push_back(d);
            m_ld = 1;
            m_err = 0;
          end
        end
      end
      2: begin
        if (a) phase = 3;
        else if (waited == TO) begin
          m_cn = 1; m_cs = 1; m_err = 1;
          digs.delete();
          phase = 0;
        end else waited++;
      end
      default: begin
        if (pp) begin
          m_cn = 1; m_cs = 1; m_err = 0;
          digs.delete();
          phase = 0;
        end
      end
    endcase
  endtask

  task automatic step(input string tag, input bit p, input int d,
                      input bit g, input bit f, input bit a);
    push = p;
    entrada = 4'(d);
    guardar = g;
    finalizar = f;
    add_ack = a;
    model(p, d, g, f, a);
    @(posedge clk);
    #1;
    push = 0; guardar = 0; finalizar = 0; add_ack = 0;
    check(tag);
  endtask

  task automatic idle(input string tag, input int n);
    for (int i = 0; i < n; i++) step(tag, 0, 0, 0, 0, 0);
  endtask

  task automatic async_reset(input string tag);
    #2;
    rst = 1;
    #1;
    model_reset();
    check(tag);
    rst = 0;
  endtask

  initial begin
    model_reset();
    #7;
    check("reset");
    rst = 0;
    @(posedge clk);
    #1;
    check("reset_idle");

    // full A+B sum flow, ack on the 5th request cycle
    step("dig1", 1, 1, 0, 0, 0);
    step("dig2", 1, 2, 0, 0, 0);
    idle("gap", 1);
    step("dig3", 1, 3, 0, 0, 0);
    step("save_a", 0, 0, 1, 0, 0);
    step("dig4", 1, 4, 0, 0, 0);
    step("dig5", 1, 5, 0, 0, 0);
    step("fin", 0, 0, 0, 1, 0);
    idle("req_hold", 4);
    step("ack", 0, 0, 0, 0, 1);
    idle("show_hold", 2);
    step("show_guard", 0, 0, 1, 0, 0);
    step("show_push9", 1, 9, 0, 0, 0);

    // digit limit and invalid digit
    step("lim1", 1, 1, 0, 0, 0);
    step("lim2", 1, 2, 0, 0, 0);
    step("lim3", 1, 3, 0, 0, 0);
    step("lim4", 1, 4, 0, 0, 0);
    step("badA", 1, 10, 0, 0, 0);
    step("lim_save", 0, 0, 1, 0, 0);

    // ignored pulses with empty operand
    async_reset("rst2");
    step("g_empty", 0, 0, 1, 0, 0);
    step("f_in_a", 0, 0, 0, 1, 0);
    step("push_g", 1, 7, 1, 0, 0);
    step("ack_in_a", 0, 0, 0, 0, 1);
    step("push_f", 1, 7, 0, 1, 0);

    // timeout path
    step("t_dig", 1, 6, 0, 0, 0);
    step("t_save", 0, 0, 1, 0, 0);
    step("t_fin_empty", 0, 0, 0, 1, 0);
    step("t_dig2", 1, 8, 0, 0, 0);
    step("t_fin", 0, 0, 0, 1, 0);
    step("t_push_ign", 1, 2, 1, 0, 0);
    idle("t_wait", TO);

    // reset mid-sum
    step("r_dig", 1, 1, 0, 0, 0);
    step("r_save", 0, 0, 1, 0, 0);
    step("r_dig2", 1, 2, 0, 0, 0);
    step("r_fin", 0, 0, 0, 1, 0);
    idle("r_wait", 2);
    async_reset("rst_suma");
    idle("after_rst", 1);

    // random pulses
    for (int i = 0; i < 600; i++) begin
      bit p, g, f, a;
      int d;
      p = ($urandom % 3) == 0;
      d = int'($urandom % 12);
      g = ($urandom % 7) == 0;
      f = ($urandom % 7) == 0;
      a = ($urandom % 6) == 0;
      step("rand", p, d, g, f, a);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/secuenciador_suma.md
Name: secuenciador_suma

Overview:
Control FSM for the two-operand BCD adder datapath. It turns debounced operator pulses (push, guardar, finalizar) into one-cycle datapath strobes: digit load, operand save, clears, and the add request/ack handshake. It also drives the display select `ent` between the live entry and the sum. It sits between the input-conditioning logic and the numero/numero_sv/resultado registers.

Parameters:
MAX_DIGITS, 3, maximum BCD digits accepted per operand (1..4).
ACK_TIMEOUT, 1023, cycles to wait in SUMA for add_ack before aborting (>=1).

Ports:
clk  input  1  system clock, rising edge.
rst  input  1  asynchronous reset, active-high.
push  input  1  single-cycle pulse: `entrada` holds a keyed digit.
entrada  input  4  keyed digit, sampled only when push=1.
guardar  input  1  single-cycle pulse: store operand A.
finalizar  input  1  single-cycle pulse: request the sum.
add_ack  input  1  single-cycle pulse from the adder: resultado valid.
ld_dig  output  1  pulse: shift entrada into numero.
clr_num  output  1  pulse: clear numero.
ld_sv  output  1  pulse: copy numero into numero_sv.
clr_sv  output  1  pulse: clear numero_sv.
add_req  output  1  level: adder request, held until ack or timeout.
ent  output  1  display select, 0=numero, 1=resultado.
n_dig  output  3  digits accepted in current operand (0..MAX_DIGITS).
estado  output  2  state code: ENTRY_A=0, ENTRY_B=1, SUMA=2, MOSTRAR=3.
err  output  1  sticky error flag.

Behaviour:
- All outputs registered; the strobe is high in the cycle after the input pulse (latency 1), for exactly 1 cycle.
- Reset (async, any state): estado=ENTRY_A; ld_dig, clr_num, ld_sv, clr_sv, add_req, ent, err = 0; n_dig=0; timer=0. add_req drops immediately even mid-SUMA.
- Digit rule (ENTRY_A/ENTRY_B only). A push is accepted when entrada<=9 and n_dig<MAX_DIGITS; it gives ld_dig, n_dig+1, and err=0.
  - entrada>9: no ld_dig, err=1, n_dig unchanged.
  - n_dig==MAX_DIGITS: push silently ignored, err unchanged.
- ENTRY_A, guardar with n_dig>=1: ld_sv=1 and clr_num=1 in the same cycle, n_dig=0, go to ENTRY_B. guardar with n_dig==0 is ignored. finalizar is ignored.
- ENTRY_B, finalizar with n_dig>=1: add_req=1, timer=0, go to SUMA. finalizar with n_dig==0 is ignored. guardar is ignored.
- SUMA: add_req stays 1 and timer increments each cycle. push, guardar and finalizar are ignored.
  - add_ack: add_req=0, ent=1, go to MOSTRAR.
  - timer reaches ACK_TIMEOUT-1 without ack: add_req=0, clr_num=1, clr_sv=1, err=1, n_dig=0, go to ENTRY_A.
  - ack on the timeout cycle: ack wins.
- MOSTRAR: ent=1 and is held. guardar and finalizar are ignored. Any push gives clr_num=1, clr_sv=1, ent=0, err=0, n_dig=0, and go to ENTRY_A. The pushed digit is discarded, not loaded.
- Simultaneous pulses: finalizar > guardar > push. The losing pulse is dropped, not queued.
- add_ack outside SUMA is ignored.
- n_dig never wraps. timer saturates and is cleared on entry to SUMA.

Test Plan:
- Reset then push 1,2,3, guardar, push 4,5, finalizar, add_ack after 5 cycles:
  - 3 ld_dig pulses, then ld_sv+clr_num in one cycle.
  - 2 ld_dig pulses, then add_req high for 5 cycles.
  - Then ent=1, estado=3.
- MAX_DIGITS=3: push 1,2,3,4 -> exactly 3 ld_dig, n_dig=3, err=0. Then push entrada=4'hA -> no ld_dig, err=1. Then guardar -> ld_sv.
- guardar with n_dig=0 and finalizar in ENTRY_A -> no strobes, estado stays 0. Then push 7 together with guardar -> no ld_dig, guardar ignored since n_dig=0.
- ACK_TIMEOUT=8, enter SUMA, no ack -> add_req high 8 cycles, then clr_num=clr_sv=1, err=1, estado=0.
- In MOSTRAR, push 9 -> clr_num=clr_sv=1, ent=0, n_dig=0, estado=0, no ld_dig.
- Assert rst during SUMA -> add_req=0 before the next clk edge, all outputs at reset values.
